// File: rtl/ctrl_pipe_pkg.sv
// Shared opcode map, writeback select encodings and per-stage control bundles
// for the pipelined controller.
package ctrl_pipe_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [3:0] ADD    = 4'h0;
    localparam logic [3:0] SUB    = 4'h1;
    localparam logic [3:0] XOR    = 4'h2;
    localparam logic [3:0] RED    = 4'h3;
    localparam logic [3:0] SLL    = 4'h4;
    localparam logic [3:0] SRA    = 4'h5;
    localparam logic [3:0] ROR    = 4'h6;
    localparam logic [3:0] PADDSB = 4'h7;
    localparam logic [3:0] LW     = 4'h8;
    localparam logic [3:0] SW     = 4'h9;
    localparam logic [3:0] LLB    = 4'hA;
    localparam logic [3:0] LHB    = 4'hB;
    localparam logic [3:0] B      = 4'hC;
    localparam logic [3:0] BR     = 4'hD;
    localparam logic [3:0] PCS    = 4'hE;
    localparam logic [3:0] HLT    = 4'hF;

    localparam logic [1:0] DST_ALU  = 2'b00;
    localparam logic [1:0] DST_MEM  = 2'b01;
    localparam logic [1:0] DST_BYTE = 2'b10;
    localparam logic [1:0] DST_PC   = 2'b11;

    // Nested so each stage register carries only the fields its successors consume.
    typedef struct packed {
        logic       writeReg;
        logic       loadByte;
        logic [1:0] dstSel;
        logic       isHlt;
    } wbCtrl_t;

    typedef struct packed {
        logic    memEn;
        logic    memWr;
        wbCtrl_t wb;
    } memCtrl_t;

    typedef struct packed {
        logic     aluImm;
        memCtrl_t mem;
    } exCtrl_t;

    typedef struct packed {
        logic    usesRs;
        logic    usesRt;
        exCtrl_t ex;
    } ctrl_t;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Instruction-side and datapath-side signals of the pipelined controller.
interface ctrl_pipe_if #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned RW   = 4,
    parameter int unsigned CNTW = 16
);
    logic            id_valid;
    logic [OPW-1:0]  id_opcode;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic [RW-1:0]   id_rd;
    logic            flush_id;
    logic            mem_ready;

    logic            ex_alu_imm;
    logic [OPW-1:0]  ex_op;
    logic            mem_en;
    logic            mem_wr;
    logic            wb_write_reg;
    logic [1:0]      wb_dst_sel;
    logic            wb_load_byte;
    logic [RW-1:0]   wb_rd;
    logic            stall_fetch;
    logic            bubble;
    logic            halted;
    logic [CNTW-1:0] stall_count;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, flush_id, mem_ready,
        input  ex_alu_imm, ex_op, mem_en, mem_wr, wb_write_reg, wb_dst_sel,
               wb_load_byte, wb_rd, stall_fetch, bubble, halted, stall_count
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, flush_id, mem_ready,
        output ex_alu_imm, ex_op, mem_en, mem_wr, wb_write_reg, wb_dst_sel,
               wb_load_byte, wb_rd, stall_fetch, bubble, halted, stall_count
    );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode-to-control-bundle table; shared with the trace monitor.
module ctrl_decode
    import ctrl_pipe_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.usesRs             = (opcode <= SW) || (opcode == BR);
        ctrl.usesRt             = (opcode <= RED) || (opcode == PADDSB) || (opcode == SW);
        ctrl.ex.aluImm          = opcode inside {SLL, SRA, ROR};
        ctrl.ex.mem.memEn       = (opcode == LW) || (opcode == SW);
        ctrl.ex.mem.memWr       = (opcode == SW);
        ctrl.ex.mem.wb.writeReg = (opcode <= LW) || opcode inside {LLB, LHB, PCS};
        ctrl.ex.mem.wb.loadByte = opcode inside {LLB, LHB};
        ctrl.ex.mem.wb.isHlt    = (opcode == HLT);
        case (opcode)
            LW:       ctrl.ex.mem.wb.dstSel = DST_MEM;
            LLB, LHB: ctrl.ex.mem.wb.dstSel = DST_BYTE;
            PCS:      ctrl.ex.mem.wb.dstSel = DST_PC;
            default:  ctrl.ex.mem.wb.dstSel = DST_ALU;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined controller: ID decode, registered EX/MEM/WB control, load-use bubbles,
// branch flush, memory-ready stalls, HLT drain and a saturating stall counter.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned OPW  = OPCODE_W,
    parameter int unsigned RW   = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    ctrl_t idCtrl;

    ctrl_decode uDecode (
        .opcode (bus.id_opcode),
        .ctrl   (idCtrl)
    );

    logic            exValidQ;
    logic [OPW-1:0]  exOpQ;
    logic [RW-1:0]   exRdQ;
    exCtrl_t         exCtrlQ;
    logic            memValidQ;
    logic [RW-1:0]   memRdQ;
    memCtrl_t        memCtrlQ;
    logic            wbValidQ;
    logic [RW-1:0]   wbRdQ;
    wbCtrl_t         wbCtrlQ;
    logic            haltPendingQ;
    logic            haltedQ;
    logic [CNTW-1:0] stallCountQ;

    logic memStall;
    logic loadUse;
    logic issue;
    logic stallFetch;
    logic haltNow;

    always_comb begin
        memStall = memValidQ && memCtrlQ.memEn && !bus.mem_ready;
        // Register 0 is hardwired, so a load into it never creates a dependency.
        loadUse  = exValidQ && (exOpQ == OPW'(LW)) && bus.id_valid && !haltPendingQ
                && (exRdQ != '0)
                && ((idCtrl.usesRs && (bus.id_rs == exRdQ))
                 || (idCtrl.usesRt && (bus.id_rt == exRdQ)));
        issue      = bus.id_valid && !bus.flush_id && !loadUse && !haltPendingQ;
        stallFetch = memStall || haltPendingQ || (loadUse && !bus.flush_id);
        haltNow    = haltedQ || (wbValidQ && wbCtrlQ.isHlt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exValidQ     <= 1'b0;
            exOpQ        <= '0;
            exRdQ        <= '0;
            exCtrlQ      <= '0;
            memValidQ    <= 1'b0;
            memRdQ       <= '0;
            memCtrlQ     <= '0;
            wbValidQ     <= 1'b0;
            wbRdQ        <= '0;
            wbCtrlQ      <= '0;
            haltPendingQ <= 1'b0;
            haltedQ      <= 1'b0;
            stallCountQ  <= '0;
        end else begin
            if (!memStall) begin
                exValidQ     <= issue;
                exOpQ        <= bus.id_opcode;
                exRdQ        <= bus.id_rd;
                exCtrlQ      <= idCtrl.ex;
                memValidQ    <= exValidQ;
                memRdQ       <= exRdQ;
                memCtrlQ     <= exCtrlQ.mem;
                wbValidQ     <= memValidQ;
                wbRdQ        <= memRdQ;
                wbCtrlQ      <= memCtrlQ.wb;
                haltPendingQ <= haltPendingQ || (issue && idCtrl.ex.mem.wb.isHlt);
            end
            haltedQ <= haltNow;
            if (stallFetch && !haltNow && (stallCountQ != '1)) begin
                stallCountQ <= stallCountQ + CNTW'(1);
            end
        end
    end

    always_comb begin
        bus.ex_alu_imm   = exValidQ && exCtrlQ.aluImm;
        bus.ex_op        = exValidQ ? exOpQ : '0;
        bus.mem_en       = memValidQ && memCtrlQ.memEn;
        bus.mem_wr       = memValidQ && memCtrlQ.memWr;
        bus.wb_write_reg = wbValidQ && wbCtrlQ.writeReg;
        bus.wb_dst_sel   = wbValidQ ? wbCtrlQ.dstSel : 2'b00;
        bus.wb_load_byte = wbValidQ && wbCtrlQ.loadByte;
        bus.wb_rd        = wbValidQ ? wbRdQ : '0;
        bus.stall_fetch  = stallFetch;
        bus.bubble       = !memStall && (bus.flush_id || loadUse);
        bus.halted       = haltNow;
        bus.stall_count  = stallCountQ;
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: inputs driven 1 time unit after the rising edge,
// outputs sampled on the falling edge.
module tb_ctrl_pipe;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_LW  = 4'h8;
    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_PCS = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.OPW(4), .RW(4), .CNTW(16)) bus ();

    ctrl_pipe #(.OPW(4), .RW(4), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
        nChecks++;
        if (got != exp) begin
            nFails++;
            $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle, drive ID-side inputs, then wait for the sampling edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [3:0] rs,
                       input logic [3:0] rt, input logic [3:0] rd, input logic fl,
                       input logic mr);
        @(posedge clk);
        #1;
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.id_rd     = rd;
        bus.flush_id  = fl;
        bus.mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.id_valid  = 1'b0;
        bus.id_opcode = '0;
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.id_rd     = '0;
        bus.flush_id  = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkEq("rst_outputs", {bus.ex_alu_imm, bus.ex_op, bus.mem_en, bus.mem_wr,
                bus.wb_write_reg, bus.wb_dst_sel, bus.wb_load_byte, bus.wb_rd,
                bus.stall_fetch, bus.bubble, bus.halted}, 0);
        checkEq("rst_count", bus.stall_count, 0);
        rst = 1'b0;

        // Plain issue and decode through all stages.
        cyc(1, OP_ADD, 1, 2, 3, 0, 1);
        checkEq("add_c0_stall", bus.stall_fetch, 0);
        checkEq("add_c0_bubble", bus.bubble, 0);
        cyc(1, OP_SLL, 1, 0, 4, 0, 1);
        checkEq("add_c1_exop", bus.ex_op, 0);
        checkEq("add_c1_imm", bus.ex_alu_imm, 0);
        cyc(1, OP_LLB, 0, 0, 7, 0, 1);
        checkEq("sll_c2_exop", bus.ex_op, 4);
        checkEq("sll_c2_imm", bus.ex_alu_imm, 1);
        checkEq("add_c2_memen", bus.mem_en, 0);
        cyc(1, OP_PCS, 0, 0, 9, 0, 1);
        checkEq("llb_c3_exop", bus.ex_op, 10);
        checkEq("add_c3_wbw", bus.wb_write_reg, 1);
        checkEq("add_c3_wbrd", bus.wb_rd, 3);
        checkEq("add_c3_dst", bus.wb_dst_sel, 0);
        idle();
        checkEq("pcs_c4_exop", bus.ex_op, 14);
        checkEq("sll_c4_wbrd", bus.wb_rd, 4);
        idle();
        checkEq("llb_c5_wbrd", bus.wb_rd, 7);
        checkEq("llb_c5_dst", bus.wb_dst_sel, 2);
        checkEq("llb_c5_lb", bus.wb_load_byte, 1);
        idle();
        checkEq("pcs_c6_dst", bus.wb_dst_sel, 3);
        checkEq("pcs_c6_lb", bus.wb_load_byte, 0);
        idle();
        checkEq("drain_wbw", bus.wb_write_reg, 0);
        checkEq("t1_count", bus.stall_count, 0);

        // Load-use via rs: one bubble, consumer lands in WB one cycle late.
        cyc(1, OP_LW, 1, 0, 5, 0, 1);
        cyc(1, OP_ADD, 5, 2, 6, 0, 1);
        checkEq("lu_bubble", bus.bubble, 1);
        checkEq("lu_stall", bus.stall_fetch, 1);
        cyc(1, OP_ADD, 5, 2, 6, 0, 1);
        checkEq("lu_c2_bubble", bus.bubble, 0);
        checkEq("lu_c2_stall", bus.stall_fetch, 0);
        checkEq("lw_c2_memen", bus.mem_en, 1);
        checkEq("lw_c2_memwr", bus.mem_wr, 0);
        idle();
        checkEq("lw_c3_wbrd", bus.wb_rd, 5);
        checkEq("lw_c3_dst", bus.wb_dst_sel, 1);
        idle();
        checkEq("lu_c4_wbw", bus.wb_write_reg, 0);
        idle();
        checkEq("lu_c5_wbw", bus.wb_write_reg, 1);
        checkEq("lu_c5_wbrd", bus.wb_rd, 6);
        checkEq("lu_count", bus.stall_count, 1);

        // rd=0 never hazards; B reads no registers; SW hazards through rt.
        cyc(1, OP_LW, 0, 0, 0, 0, 1);
        cyc(1, OP_ADD, 0, 0, 8, 0, 1);
        checkEq("r0_bubble", bus.bubble, 0);
        checkEq("r0_stall", bus.stall_fetch, 0);
        cyc(1, OP_LW, 0, 0, 2, 0, 1);
        cyc(1, OP_B, 2, 2, 0, 0, 1);
        checkEq("b_bubble", bus.bubble, 0);
        checkEq("lw0_wbw", bus.wb_write_reg, 1);
        checkEq("lw0_wbrd", bus.wb_rd, 0);
        cyc(1, OP_LW, 0, 0, 2, 0, 1);
        checkEq("add8_wbrd", bus.wb_rd, 8);
        cyc(1, OP_SW, 0, 2, 0, 0, 1);
        checkEq("rt_bubble", bus.bubble, 1);
        checkEq("rt_stall", bus.stall_fetch, 1);
        cyc(1, OP_SW, 0, 2, 0, 0, 1);
        checkEq("rt_c6_bubble", bus.bubble, 0);
        idle();
        idle();
        checkEq("sw_memwr", bus.mem_wr, 1);
        idle();
        checkEq("sw_wbw", bus.wb_write_reg, 0);
        checkEq("t3_count", bus.stall_count, 2);

        // SW waits three cycles on mem_ready; everything freezes.
        cyc(1, OP_SW, 1, 2, 0, 0, 1);
        cyc(1, OP_SUB, 1, 1, 10, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, OP_XOR, 3, 3, 11, 0, 0);
            checkEq("ms_stall", bus.stall_fetch, 1);
            checkEq("ms_memen", bus.mem_en, 1);
            checkEq("ms_memwr", bus.mem_wr, 1);
            checkEq("ms_exop", bus.ex_op, 1);
            checkEq("ms_bubble", bus.bubble, 0);
        end
        checkEq("ms_wbw", bus.wb_write_reg, 0);
        checkEq("ms_count_mid", bus.stall_count, 4);
        cyc(1, OP_XOR, 3, 3, 11, 0, 1);
        checkEq("ms_release", bus.stall_fetch, 0);
        checkEq("ms_rel_memwr", bus.mem_wr, 1);
        idle();
        checkEq("ms_xor_exop", bus.ex_op, 2);
        checkEq("ms_sw_wbw", bus.wb_write_reg, 0);
        checkEq("ms_count", bus.stall_count, 5);
        idle();
        checkEq("ms_sub_wbrd", bus.wb_rd, 10);
        idle();
        checkEq("ms_xor_wbrd", bus.wb_rd, 11);

        // Flush wins over load-use; squashed ADD never writes back.
        cyc(1, OP_LW, 0, 0, 6, 0, 1);
        cyc(1, OP_ADD, 6, 0, 12, 1, 1);
        checkEq("fl_bubble", bus.bubble, 1);
        checkEq("fl_stall", bus.stall_fetch, 0);
        idle();
        idle();
        checkEq("fl_lw_wbrd", bus.wb_rd, 6);
        idle();
        checkEq("fl_sq_wbw", bus.wb_write_reg, 0);
        checkEq("fl_count", bus.stall_count, 5);

        // HLT drains older work, blocks younger, halts, and reset clears it.
        cyc(1, OP_ADD, 0, 0, 1, 0, 1);
        cyc(1, OP_HLT, 0, 0, 0, 0, 1);
        checkEq("h_c1_stall", bus.stall_fetch, 0);
        cyc(1, OP_SUB, 0, 0, 2, 0, 1);
        checkEq("h_c2_stall", bus.stall_fetch, 1);
        checkEq("h_c2_halted", bus.halted, 0);
        cyc(1, OP_SUB, 0, 0, 2, 0, 1);
        checkEq("h_c3_halted", bus.halted, 0);
        checkEq("h_add_wbrd", bus.wb_rd, 1);
        cyc(1, OP_SUB, 0, 0, 2, 0, 1);
        checkEq("h_c4_halted", bus.halted, 1);
        checkEq("h_c4_wbw", bus.wb_write_reg, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, OP_SUB, 0, 0, 2, 0, 1);
            checkEq("h_sticky", bus.halted, 1);
            checkEq("h_no_sub_wb", bus.wb_write_reg, 0);
            checkEq("h_no_sub_ex", bus.ex_op, 0);
        end
        checkEq("h_count", bus.stall_count, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.id_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkEq("h_rst_halted", bus.halted, 0);
        checkEq("h_rst_count", bus.stall_count, 0);
        checkEq("h_rst_stall", bus.stall_fetch, 0);

        // Flushed HLT never arms the halt.
        cyc(1, OP_HLT, 0, 0, 0, 1, 1);
        checkEq("fh_bubble", bus.bubble, 1);
        idle();
        checkEq("fh_stall", bus.stall_fetch, 0);
        repeat (3) idle();
        checkEq("fh_halted", bus.halted, 0);
        checkEq("fh_stall_late", bus.stall_fetch, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the 4-bit ISA opcode in ID and carries the control bundle through registered EX, MEM and WB stages.
- Adds load-use bubble insertion, branch flush, a multi-cycle memory ready handshake, HLT drain/halt, and a saturating stall counter.
- Sits between the fetch/decode register file read and the datapath stage muxes.

Parameters:
- OPW, 4, opcode width; decode table below is defined for 4.
- RW, 4, register-index width.
- CNTW, 16, stall-counter width; the counter saturates at all-ones.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_opcode  in  OPW  ID opcode.
- id_rs  in  RW  ID source index 1.
- id_rt  in  RW  ID source index 2.
- id_rd  in  RW  ID destination index.
- flush_id  in  1  branch taken; squash the ID instruction.
- mem_ready  in  1  memory completes the MEM-stage access this cycle.
- ex_alu_imm  out  1  EX ALU operand 2 is the immediate.
- ex_op  out  OPW  EX opcode for ALU function select.
- mem_en  out  1  MEM-stage memory enable.
- mem_wr  out  1  1 = write, 0 = read.
- wb_write_reg  out  1  register-file write enable.
- wb_dst_sel  out  2  00 ALU, 01 memory data, 10 load-byte, 11 PC+2.
- wb_load_byte  out  1  LLB/LHB path select.
- wb_rd  out  RW  WB destination index.
- stall_fetch  out  1  hold PC and the IF/ID register.
- bubble  out  1  ID/EX loaded with a bubble this cycle.
- halted  out  1  sticky; HLT reached WB.
- stall_count  out  CNTW  cycles with stall_fetch=1.

Behaviour:
- Decode (combinational, ID):
  - write_reg=1 for 0000–1000, 1010, 1011, 1110.
  - alu_imm=1 for 0100–0110.
  - load_byte=1 for 1010/1011.
  - dst_sel: 01 for LW, 10 for LLB/LHB, 11 for PCS, else 00.
  - mem_en for 1000/1001; mem_wr for 1001 only.
  - uses_rs for 0000–1001 and 1101.
  - uses_rt for 0000–0011, 0111 and 1001.
  - is_hlt for 1111.
- Stage registers ID/EX, EX/MEM and MEM/WB each hold a valid bit, opcode, rd and the remaining control fields.
- All outputs are gated by their stage's valid bit: an invalid stage drives 0.
- Latency: an instruction presented in ID at cycle N appears on ex_* at N+1, mem_* at N+2 and wb_* at N+3, absent stalls.
- Memory stall:
  - Condition: EX/MEM valid and mem_en=1 and mem_ready=0.
  - Every stage register holds and stall_fetch=1.
  - flush_id and the hazard check are ignored; the branch unit holds flush_id until the stall clears.
- Load-use hazard:
  - Condition: ID/EX valid, ID/EX opcode=LW, id_valid, and ID/EX rd matches id_rs (uses_rs) or id_rt (uses_rt).
  - rd=0 never matches.
  - Response: ID/EX is loaded with valid=0, bubble=1, stall_fetch=1 for exactly 1 cycle.
- Flush:
  - flush_id=1 loads ID/EX with valid=0.
  - Flush takes priority over the load-use hazard: bubble=1, stall_fetch=0 in that cycle.
- Priority: rst > memory stall > flush > load-use > normal advance.
- HLT:
  - A valid HLT entering ID/EX sets halt_pending; thereafter stall_fetch=1 permanently and ID/EX loads valid=0.
  - Older instructions drain.
  - halted sets when HLT is valid in MEM/WB and stays set until rst.
  - A flush in the cycle HLT is in ID squashes it: no halt_pending.
- stall_count increments on each cycle with stall_fetch=1 and halted=0, and saturates at 2^CNTW-1.
- Reset:
  - All valid bits, halt_pending and halted go to 0; stall_count goes to 0.
  - Every output is 0.
  - A reset mid-stall or mid-drain discards all in-flight state.

Decomposition:
- Shared package holds the opcode localparams (ADD..HLT) and the dst_sel encodings.
- One sub-module, ctrl_decode: the purely combinational opcode-to-bundle table, reused by the disassembler/trace monitor.
- Hazard, stall and stage registers stay in ctrl_pipe.

Test Plan:
- rst, then ADD rd=3 at cycle 0 → ex_op=0000 at 1; wb_write_reg=1, wb_rd=3, wb_dst_sel=00 at 3; stall_count=0.
- LW rd=5 then ADD rs=5 → bubble=1 and stall_fetch=1 for one cycle; ADD reaches WB 1 cycle late; stall_count=1.
- LW rd=0 then ADD rs=0 → no bubble, no stall.
- SW with mem_ready low for 3 cycles → mem_en=1, mem_wr=1 held; all stages frozen; stall_count=3; wb_write_reg never 1 for the SW.
- flush_id together with a load-use condition → bubble=1, stall_fetch=0; the squashed instruction never reaches WB.
- ADD, HLT, SUB → SUB never issued; halted=1 three cycles after HLT in ID and stays set; rst clears it to 0.
